// File: rtl/rr_bank_scheduler.sv
// rr_bank_scheduler
//   Work-conserving round-robin scheduler between NCONSUMERS requesters and a
//   banked PLM (NBANKS banks x NPORTS ports). Each (bank, port) kernel grants
//   one eligible request per cycle, drives its PLM port, and carries a tag
//   through a PLM_LATENCY-deep pipeline so read data returns to the consumer
//   that issued the read.
//
// Ports
//   clk             in   clock, all state on rising edge
//   reset           in   asynchronous, active-high
//   i_requests[c]   in   {addr, value, wr, valid}, valid is bit 0
//   o_grants        out  combinational, request c accepted this cycle
//   o_plm_inputs[k] out  {addr minus bank bits, value, wr}, zero when idle
//   o_plm_valid     out  combinational, kernel k issues an access this cycle
//   i_plm_outputs[k] in  PLM read data, PLM_LATENCY cycles after issue
//   o_resp_valid    out  registered, read data valid for consumer c
//   o_resp_data[c]  out  registered read data
module rr_bank_scheduler #(
  parameter int ADDR_WIDTH = 4,
  parameter int VALUE_WIDTH = 8,
  parameter int NCONSUMERS = 4,
  parameter int NBANKS = 2,
  parameter int NPORTS = 2,
  parameter int PLM_LATENCY = 1,
  localparam int NUM_BANK_BITS = $clog2(NBANKS),
  localparam int REQ_WIDTH = ADDR_WIDTH + VALUE_WIDTH + 2,
  localparam int PLM_INPUT_WIDTH = ADDR_WIDTH - NUM_BANK_BITS + VALUE_WIDTH + 1,
  localparam int NKERNELS = NBANKS * NPORTS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [REQ_WIDTH-1:0]       i_requests [NCONSUMERS],
  output logic [NCONSUMERS-1:0]      o_grants,
  output logic [PLM_INPUT_WIDTH-1:0] o_plm_inputs [NKERNELS],
  output logic [NKERNELS-1:0]        o_plm_valid,
  input  logic [VALUE_WIDTH-1:0]     i_plm_outputs [NKERNELS],
  output logic [NCONSUMERS-1:0]      o_resp_valid,
  output logic [VALUE_WIDTH-1:0]     o_resp_data [NCONSUMERS]
);

  localparam int LOCAL_ADDR_WIDTH = ADDR_WIDTH - NUM_BANK_BITS;
  localparam int ID_WIDTH = $clog2(NCONSUMERS);

  if (NPORTS < 1 || NPORTS > 2) begin : g_bad_nports
    $error("rr_bank_scheduler: NPORTS must be 1 or 2");
  end

  logic [NCONSUMERS-1:0]      w_req_valid;
  logic [NCONSUMERS-1:0]      w_req_wr;
  logic [ADDR_WIDTH-1:0]      w_req_bank [NCONSUMERS];
  logic [PLM_INPUT_WIDTH-1:0] w_req_plm [NCONSUMERS];

  logic [NCONSUMERS-1:0]      w_grants;
  logic [NKERNELS-1:0]        w_plm_valid;
  logic [NKERNELS-1:0]        w_rd_issue;
  logic [ID_WIDTH-1:0]        w_sel [NKERNELS];
  logic [PLM_INPUT_WIDTH-1:0] w_plm_inputs [NKERNELS];
  int                         w_scan;

  logic [ID_WIDTH-1:0]        r_pivot [NKERNELS];
  logic                       r_tag_rd [NKERNELS][PLM_LATENCY];
  logic [ID_WIDTH-1:0]        r_tag_id [NKERNELS][PLM_LATENCY];
  logic [NCONSUMERS-1:0]      r_resp_valid;
  logic [VALUE_WIDTH-1:0]     r_resp_data [NCONSUMERS];

  function automatic logic [ID_WIDTH-1:0] pivot_reset(input int k);
    return ID_WIDTH'(((k / NPORTS) + (k % NPORTS) * (NCONSUMERS / NPORTS)) % NCONSUMERS);
  endfunction

  for (genvar c = 0; c < NCONSUMERS; c++) begin : g_decode
    logic [ADDR_WIDTH-1:0] w_addr;
    assign w_addr         = i_requests[c][REQ_WIDTH-1 -: ADDR_WIDTH];
    assign w_req_valid[c] = i_requests[c][0];
    assign w_req_wr[c]    = i_requests[c][1];
    // Shifting out the in-bank bits leaves the bank number; with a single
    // bank this shifts everything out and every request matches bank 0.
    assign w_req_bank[c]  = w_addr >> LOCAL_ADDR_WIDTH;
    assign w_req_plm[c]   = {w_addr[LOCAL_ADDR_WIDTH-1:0],
                             i_requests[c][VALUE_WIDTH+1:2], w_req_wr[c]};
  end

  // Ports of a bank are resolved in order so a consumer taken by port 0 is
  // invisible to port 1. Consumers target one bank only, so one shared grant
  // vector is enough to enforce a single grant per consumer.
  always_comb begin
    w_grants    = '0;
    w_plm_valid = '0;
    w_rd_issue  = '0;
    w_scan      = 0;
    for (int k = 0; k < NKERNELS; k++) begin
      w_sel[k]        = '0;
      w_plm_inputs[k] = '0;
    end
    for (int b = 0; b < NBANKS; b++) begin
      for (int p = 0; p < NPORTS; p++) begin
        for (int j = 0; j < NCONSUMERS; j++) begin
          // explicit wrap: NCONSUMERS need not be a power of two
          w_scan = int'(r_pivot[b*NPORTS+p]) + j;
          if (w_scan >= NCONSUMERS) w_scan = w_scan - NCONSUMERS;
          if (!w_plm_valid[b*NPORTS+p] && w_req_valid[w_scan] &&
              (w_req_bank[w_scan] == ADDR_WIDTH'(b)) && !w_grants[w_scan]) begin
            w_plm_valid[b*NPORTS+p]  = 1'b1;
            w_grants[w_scan]         = 1'b1;
            w_sel[b*NPORTS+p]        = ID_WIDTH'(w_scan);
            w_plm_inputs[b*NPORTS+p] = w_req_plm[w_scan];
            w_rd_issue[b*NPORTS+p]   = ~w_req_wr[w_scan];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < NKERNELS; k++) begin
        r_pivot[k] <= pivot_reset(k);
        for (int s = 0; s < PLM_LATENCY; s++) begin
          r_tag_rd[k][s] <= 1'b0;
          r_tag_id[k][s] <= '0;
        end
      end
    end else begin
      for (int k = 0; k < NKERNELS; k++) begin
        if (w_plm_valid[k]) begin
          r_pivot[k] <= (w_sel[k] == ID_WIDTH'(NCONSUMERS - 1)) ? '0 : w_sel[k] + 1'b1;
        end
        r_tag_rd[k][0] <= w_rd_issue[k];
        r_tag_id[k][0] <= w_sel[k];
        for (int s = 1; s < PLM_LATENCY; s++) begin
          r_tag_rd[k][s] <= r_tag_rd[k][s-1];
          r_tag_id[k][s] <= r_tag_id[k][s-1];
        end
      end
    end
  end

  // At most one kernel per consumer can hold a read tag at the tail, since a
  // consumer is granted at most once per cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_resp_valid <= '0;
      for (int c = 0; c < NCONSUMERS; c++) r_resp_data[c] <= '0;
    end else begin
      r_resp_valid <= '0;
      for (int k = 0; k < NKERNELS; k++) begin
        if (r_tag_rd[k][PLM_LATENCY-1]) begin
          r_resp_valid[r_tag_id[k][PLM_LATENCY-1]] <= 1'b1;
          r_resp_data[r_tag_id[k][PLM_LATENCY-1]]  <= i_plm_outputs[k];
        end
      end
    end
  end

  assign o_grants     = w_grants;
  assign o_plm_valid  = w_plm_valid;
  assign o_plm_inputs = w_plm_inputs;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_data  = r_resp_data;

endmodule

// File: doc/rr_bank_scheduler.md
# rr_bank_scheduler

Work-conserving round-robin scheduler sitting between NCONSUMERS request sources and a banked PLM of NBANKS banks with NPORTS ports each. Each cycle, every (bank, port) kernel grants one eligible request, skipping idle consumers, and drives the PLM port. Read data is routed back to the granting consumer after a parametrised PLM latency. This block is the successor to the fixed-rotation per-port kernel: it adds request skipping, per-consumer grant handshake and response routing.

## Interface
- ADDR_WIDTH, 4, request address width; top NUM_BANK_BITS=$clog2(NBANKS) bits select the bank
- VALUE_WIDTH, 8, data width
- NCONSUMERS, 4, number of requesters (>=2, any integer, need not be a power of two)
- NBANKS, 2, number of PLM banks (>=1)
- NPORTS, 2, ports per bank (1 or 2; other values fail an elaboration assertion)
- PLM_LATENCY, 1, cycles from PLM input capture to valid plm_outputs (>=1)
- Derived: REQ_WIDTH=ADDR_WIDTH+VALUE_WIDTH+2; PLM_INPUT_WIDTH=ADDR_WIDTH-NUM_BANK_BITS+VALUE_WIDTH+1; NKERNELS=NBANKS*NPORTS; kernel k=bank*NPORTS+port
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- requests[NCONSUMERS]  input  REQ_WIDTH  {addr, value, wr, valid}, valid is bit 0
- grants  output  NCONSUMERS  combinational; grants[c]=1 means request c accepted this cycle
- plm_inputs[NKERNELS]  output  PLM_INPUT_WIDTH  {addr minus bank bits, value, wr}; all zeros when idle
- plm_valid  output  NKERNELS  combinational; kernel k issued an access this cycle
- plm_outputs[NKERNELS]  input  VALUE_WIDTH  PLM read data, PLM_LATENCY cycles after issue
- resp_valid  output  NCONSUMERS  registered; read data for consumer c on resp_data[c]
- resp_data[NCONSUMERS]  output  VALUE_WIDTH  registered read data

## Operation
- Eligibility for kernel (b,p): requests[c].valid=1, bank field==b (NBANKS=1: always true), and c not granted by any port p'<p of bank b this cycle.
- Selection: first eligible consumer scanning c=pivot, pivot+1, ... modulo NCONSUMERS (explicit modulo, not bit wrap). No eligible consumer: plm_valid[k]=0, plm_inputs[k]=0.
- A consumer receives at most one grant per cycle. Consumers hold their request stable until grants[c]=1; a granted request is consumed at that clock edge.
- Pivot update at each edge: grant to c -> pivot=(c+1) mod NCONSUMERS; no grant -> unchanged.
- Pivot reset value: (b + p*(NCONSUMERS/NPORTS)) mod NCONSUMERS.
- Per-kernel tag pipeline of PLM_LATENCY stages carries {read_valid=plm_valid&~wr, consumer id}. At tail with read_valid=1, resp_valid[id]<=1, resp_data[id]<=plm_outputs[k] at next edge; else resp_valid[id]<=0, resp_data holds.
- Writes never generate responses. Same-address conflicts between two ports of a bank are not resolved here.

## Timing
- Grant and PLM drive: same cycle T as request (combinational path requests->grants/plm_inputs).
- Read response: resp_valid high in cycle T+PLM_LATENCY+1, exactly one cycle wide per read.
- Back-to-back reads from one consumer: one response per cycle, order preserved.
- Reset (async): pivots to reset values, all tag stages cleared, resp_valid=0, resp_data=0. Reads in flight at reset produce no response; plm_outputs ignored until fresh tags arrive.
- Reset released: first grants possible in the first cycle after deassertion.

## Test plan
- NCONSUMERS=4,NBANKS=2,NPORTS=2; all four hold bank-0 reads -> grants cycle0 {c0,c2}, cycle1 {c1,c3}, cycle2 {c2,c0}; bank-1 plm_valid=0 throughout.
- Only c3 valid, bank 0 -> granted every cycle by port 0 (pivot 0 skips c0-c2), port 1 idle; pivot0 becomes 0 after each grant.
- c0 reads bank 1, c1 reads bank 0 in same cycle -> both granted; resp_valid[0] and resp_valid[1] high at cycle PLM_LATENCY+1 with data from kernels 2 and 0 respectively.
- PLM_LATENCY=3, c2 writes then reads same address -> no response for write; resp_valid[2] exactly one cycle, 4 cycles after read grant.
- Reset asserted one cycle after a read grant -> resp_valid never rises for that read; pivots return to 0,2,1,3.
- NCONSUMERS=3,NBANKS=1,NPORTS=2 all valid -> pivots wrap 2->0 correctly, each consumer granted twice in three cycles.
